// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural program counter with next-PC target selection,
// fetch-valid generation and a one-cycle squash after every taken redirect.
// Optional feature macro: PC_SEQUENCER_MISALIGN_TRAP_EN. When defined, a
// register jump to a non-word-aligned address vectors to TRAP_PC and pulses
// misalign. When undefined, the low two target bits are cleared instead.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  jbsel,
    input  logic        instr_valid,
    input  logic        hold,
    input  logic [15:0] br_offset,
    input  logic [25:0] jmp_index,
    input  logic [31:0] reg_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        redirect,
    output logic        misalign
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        redirect_q, redirect_d;
    logic        misalign_q, misalign_d;

    logic [31:0] brOffsetExt;
    logic [31:0] brTarget;
    logic [31:0] jmpTarget;

`ifndef PC_SEQUENCER_MISALIGN_TRAP_EN
    // The trap vector and the low target bits play no part without the trap.
    logic unusedTrapInputs;
    assign unusedTrapInputs = ^{TRAP_PC, reg_target[1:0]};
`endif

    assign pc_plus4 = pc_q + 32'd4;

    // Candidate non-sequential targets, all relative to the current pc.
    always_comb begin
        brOffsetExt = {{14{br_offset[15]}}, br_offset, 2'b00};
        brTarget    = pc_plus4 + brOffsetExt;
        jmpTarget   = {pc_plus4[31:28], jmp_index, 2'b00};
    end

    // Next-state logic: BOOT always moves to RUN. RUN commits a sequential
    // step or a redirect. FLUSH squashes one fetch slot. Hold freezes the
    // state and clears the pulses.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_d    = 1'b0;
        misalign_d    = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!hold) begin
                    if (instr_valid && (jbsel != 2'b00)) begin
                        state_d    = FLUSH;
                        redirect_d = 1'b1;
                        unique case (jbsel)
                            2'b01:   pc_d = brTarget;
                            2'b10:   pc_d = jmpTarget;
                            default: begin
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
                                if (reg_target[1:0] != 2'b00) begin
                                    pc_d       = TRAP_PC;
                                    misalign_d = 1'b1;
                                end else begin
                                    pc_d = reg_target;
                                end
`else
                                pc_d = {reg_target[31:2], 2'b00};
`endif
                            end
                        endcase
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            FLUSH: begin
                if (!hold) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_PC;
            end
        endcase
        fetch_valid_d = (state_d == RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            redirect_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            redirect_q    <= redirect_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign redirect    = redirect_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural PC model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0080;

    logic        clk;
    logic        rst_n;
    logic [1:0]  jbsel;
    logic        instr_valid;
    logic        hold;
    logic [15:0] br_offset;
    logic [25:0] jmp_index;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        redirect;
    logic        misalign;

    int checkCount = 0;
    int errorCount = 0;

    // Behavioural model: the PC, whether the presented pc is fetchable,
    // whether the block is still coming out of reset, and the pulses.
    logic [31:0] mPc;
    logic        mFetch;
    logic        mBoot;
    logic        mRed;
    logic        mMis;

    pc_sequencer #(
        .RESET_PC(RESET_PC),
        .TRAP_PC (TRAP_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .jbsel      (jbsel),
        .instr_valid(instr_valid),
        .hold       (hold),
        .br_offset  (br_offset),
        .jmp_index  (jmp_index),
        .reg_target (reg_target),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_valid(fetch_valid),
        .redirect   (redirect),
        .misalign   (misalign)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the same edge, then
    // compare every output just after the edge.
    task automatic applyStimulus(input logic rstN, input logic [1:0] sel,
                                 input logic valid, input logic hld,
                                 input logic [15:0] off, input logic [25:0] idx,
                                 input logic [31:0] tgt);
        int o;
        rst_n       = rstN;
        jbsel       = sel;
        instr_valid = valid;
        hold        = hld;
        br_offset   = off;
        jmp_index   = idx;
        reg_target  = tgt;
        @(posedge clk);
        if (!rstN) begin
            mPc = RESET_PC; mBoot = 1'b1; mFetch = 1'b0; mRed = 1'b0; mMis = 1'b0;
        end else if (mBoot) begin
            mBoot = 1'b0; mFetch = 1'b1; mRed = 1'b0; mMis = 1'b0;
        end else if (hld) begin
            mRed = 1'b0; mMis = 1'b0;
        end else if (!mFetch) begin
            mFetch = 1'b1; mRed = 1'b0; mMis = 1'b0;
        end else if (valid && sel != 2'b00) begin
            mRed = 1'b1; mFetch = 1'b0; mMis = 1'b0;
            case (sel)
                2'b01: begin
                    o   = $signed(off);
                    mPc = mPc + 32'd4 + 32'(o * 4);
                end
                2'b10: mPc = ((mPc + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
                default: begin
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
                    if (tgt % 4 != 0) begin
                        mPc  = TRAP_PC;
                        mMis = 1'b1;
                    end else begin
                        mPc = tgt;
                    end
`else
                    mPc = tgt - (tgt % 4);
`endif
                end
            endcase
        end else begin
            mPc = mPc + 32'd4; mRed = 1'b0; mMis = 1'b0;
        end
        #1;
        checkOutput("pc", pc, mPc);
        checkOutput("pc_plus4", pc_plus4, mPc + 32'd4);
        checkOutput("fetch_valid", 32'(fetch_valid), 32'(mFetch));
        checkOutput("redirect", 32'(redirect), 32'(mRed));
        checkOutput("misalign", 32'(misalign), 32'(mMis));
    endtask

    // Directed scenarios, then randomized traffic.
    initial begin
        logic [1:0] rsel;
        mPc = '0; mFetch = 1'b0; mBoot = 1'b1; mRed = 1'b0; mMis = 1'b0;
        rst_n = 1'b0; jbsel = 2'b00; instr_valid = 1'b0; hold = 1'b0;
        br_offset = '0; jmp_index = '0; reg_target = '0;

        // Reset, boot, three sequential steps.
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        checkOutput("tp_reset_pc", pc, 32'h100);
        checkOutput("tp_reset_fv", 32'(fetch_valid), 32'd0);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        checkOutput("tp_boot_fv", 32'(fetch_valid), 32'd1);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        checkOutput("tp_seq1", pc, 32'h104);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        checkOutput("tp_seq3", pc, 32'h10C);

        // Move to 0x200, then take a backward branch; FLUSH ignores a jump.
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 16'h0, 26'h0, 32'h200);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 16'hFFFE, 26'h0, 32'h0);
        checkOutput("tp_br_pc", pc, 32'h1FC);
        checkOutput("tp_br_redirect", 32'(redirect), 32'd1);
        checkOutput("tp_br_fv", 32'(fetch_valid), 32'd0);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 16'h0, 26'h3FF_FFFF, 32'h0);
        checkOutput("tp_flush_ignores", pc, 32'h1FC);
        checkOutput("tp_flush_fv", 32'(fetch_valid), 32'd1);

        // Pseudo-direct jump keeps the upper nibble of pc+4.
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 16'h0, 26'h0, 32'h3000_0010);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 16'h0, 26'h000_0040, 32'h0);
        checkOutput("tp_jmp_pc", pc, 32'h3000_0100);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);

        // Misaligned register jump.
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0000_0402);
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
        checkOutput("tp_misalign_pc", pc, 32'h80);
        checkOutput("tp_misalign_pulse", 32'(misalign), 32'd1);
`else
        checkOutput("tp_misalign_pc", pc, 32'h400);
        checkOutput("tp_misalign_pulse", 32'(misalign), 32'd0);
`endif
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);

        // Taken branch, then hold for three cycles in FLUSH.
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 16'h0003, 26'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 16'h0, 26'h0, 32'h0);
            checkOutput("tp_hold_redirect", 32'(redirect), 32'd0);
        end
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        checkOutput("tp_hold_resume", 32'(fetch_valid), 32'd1);

        // Reset in the middle of FLUSH.
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 16'h0, 26'h0, 32'h200);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 16'hFFFE, 26'h0, 32'h0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        checkOutput("tp_rst_flush_pc", pc, 32'h100);
        checkOutput("tp_rst_flush_redirect", 32'(redirect), 32'd0);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);

        // Wrap-around of sequential and branch arithmetic.
        applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        checkOutput("tp_wrap_seq", pc, 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 16'hFFFF, 26'h0, 32'h0);
        checkOutput("tp_wrap_br", pc, 32'h0);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);

        // Randomized traffic including bubbles, stalls and occasional reset.
        for (int i = 0; i < 400; i++) begin
            rsel = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 49) != 0), rsel,
                          ($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0),
                          16'($urandom), 26'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
